// File: rtl/sisc_mem_pkg.sv
// ----------------------------------------------------------------------------
// sisc_mem_pkg
//   Shared definitions for the SISC data-memory responder.
//   Contents:
//     DATA_W_DEF / ADDR_W_DEF : default data and address widths
//     CNT_W                   : width of the wait-state counter (WAIT 0..15)
//     state_t                 : responder FSM encoding
// ----------------------------------------------------------------------------
package sisc_mem_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 16;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_WAITING = 2'b01,
      ST_RESP    = 2'b10
   } state_t;

endpackage

// File: rtl/dm_ram.sv
// ----------------------------------------------------------------------------
// dm_ram
//   Single-port synchronous RAM, 2^DEPTH_W words of DATA_W bits.
//   Read data is registered (read-before-write on a store cycle); contents
//   are never reset.
//   Ports:
//     clk    in   clock, rising edge
//     en     in   port enable; nothing happens when low
//     we     in   1 = write wdata to addr, 0 = read only
//     addr   in   word address
//     wdata  in   write data
//     rdata  out  registered read data, updated on enabled edges
// ----------------------------------------------------------------------------
module dm_ram
   import sisc_mem_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int DEPTH_W = 8
) (
   input  logic               clk,
   input  logic               en,
   input  logic               we,
   input  logic [DEPTH_W-1:0] addr,
   input  logic [DATA_W-1:0]  wdata,
   output logic [DATA_W-1:0]  rdata
);

   logic [DATA_W-1:0] r_mem [0:(1 << DEPTH_W) - 1];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            r_mem[addr] <= wdata;
         end
         rdata <= r_mem[addr];
      end
   end

endmodule

// File: rtl/dm_responder.sv
// ----------------------------------------------------------------------------
// dm_responder
//   Responder end of the SISC data-memory req/ack interface. One load or
//   store is accepted at a time, held for WAIT wait states, then completed
//   with a single-cycle ack. Addresses with any bit set above DEPTH_W are
//   out of range: they complete with err = 1, never write, and read as 0.
//   Ports:
//     clk    in   clock, rising edge
//     rst_f  in   asynchronous active-low reset
//     req    in   request valid (only honoured in IDLE)
//     we     in   1 = store, 0 = load, sampled with req
//     addr   in   word address, sampled with req
//     wdata  in   store data, sampled with req
//     ack    out  one-cycle completion pulse
//     rdata  out  load data, valid with ack; holds until the next load ends
//     err    out  out-of-range flag, valid with ack
//     busy   out  high from acceptance through the ack cycle
// ----------------------------------------------------------------------------
module dm_responder
   import sisc_mem_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DEPTH_W = 8,
   parameter int WAIT    = 2
) (
   input  logic              clk,
   input  logic              rst_f,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ack,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              busy
);

   localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);

   state_t              r_state;
   state_t              w_state_next;

   logic [CNT_W-1:0]    r_cnt;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_load;    // response in flight is a load
   logic                r_err;     // response in flight is out of range
   logic [DATA_W-1:0]   r_hold;    // rdata shown outside a load's ack cycle

   logic                w_accept;
   logic                w_enter_resp;
   logic                w_cur_we;
   logic [ADDR_W-1:0]   w_cur_addr;
   logic [DATA_W-1:0]   w_cur_wdata;
   logic                w_in_range;
   logic                w_ram_en;
   logic [DATA_W-1:0]   w_ram_rdata;

   assign w_accept = (r_state == ST_IDLE) && req;

   // With WAIT = 0 the RESP entry edge is the acceptance edge itself, so the
   // memory must see the live inputs in IDLE and the latched copy otherwise.
   assign w_cur_we    = (r_state == ST_IDLE) ? we    : r_we;
   assign w_cur_addr  = (r_state == ST_IDLE) ? addr  : r_addr;
   assign w_cur_wdata = (r_state == ST_IDLE) ? wdata : r_wdata;

   generate
      if (DEPTH_W < ADDR_W) begin : g_range
         assign w_in_range = (w_cur_addr[ADDR_W-1:DEPTH_W] == '0);
      end else begin : g_full
         assign w_in_range = 1'b1;
      end
   endgenerate

   // RESP is only reachable from IDLE/WAITING, so next == RESP marks the
   // entry edge, where the store commits or the load is read.
   assign w_enter_resp = (w_state_next == ST_RESP);

   // Qualified by rst_f so a req seen while held in reset cannot reach the
   // RAM through the WAIT = 0 path.
   assign w_ram_en = w_enter_resp && w_in_range && rst_f;

   dm_ram #(
      .DATA_W  (DATA_W),
      .DEPTH_W (DEPTH_W)
   ) u_ram (
      .clk   (clk),
      .en    (w_ram_en),
      .we    (w_cur_we),
      .addr  (w_cur_addr[DEPTH_W-1:0]),
      .wdata (w_cur_wdata),
      .rdata (w_ram_rdata)
   );

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req) begin
               w_state_next = (WAIT == 0) ? ST_RESP : ST_WAITING;
            end
         end
         ST_WAITING: begin
            if (r_cnt <= 1) begin
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      ack   = 1'b0;
      busy  = 1'b0;
      err   = 1'b0;
      rdata = r_hold;
      case (r_state)
         ST_WAITING: begin
            busy = 1'b1;
         end
         ST_RESP: begin
            ack  = 1'b1;
            busy = 1'b1;
            err  = r_err;
            if (r_load) begin
               rdata = r_err ? '0 : w_ram_rdata;
            end
         end
         default: begin
         end
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_load  <= 1'b0;
         r_err   <= 1'b0;
         r_hold  <= '0;
      end else begin
         if (w_accept) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= WAIT_CNT;
         end else if (r_state == ST_WAITING) begin
            r_cnt <= r_cnt - 1'b1;
         end

         if (w_enter_resp) begin
            r_load <= !w_cur_we;
            r_err  <= !w_in_range;
         end

         // Whatever was presented in the ack cycle persists afterwards:
         // a load's result, or the unchanged value for a store.
         if (r_state == ST_RESP) begin
            r_hold <= rdata;
         end
      end
   end

endmodule

// File: tb/tb_dm_responder.sv
// Three responders (WAIT = 0, 2, 4) share one stimulus stream. A
// transaction-level model tracks, per instance, when each request was
// accepted and derives ack/busy/err/rdata from edge arithmetic.
module tb_dm_responder;

   localparam int N = 3;

   logic        clk   = 1'b0;
   logic        rst_f = 1'b0;
   logic        req   = 1'b0;
   logic        we    = 1'b0;
   logic [15:0] addr  = '0;
   logic [31:0] wdata = '0;

   logic        ack_w  [N];
   logic        busy_w [N];
   logic        err_w  [N];
   logic [31:0] rd_w   [N];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      dm_responder #(
         .DATA_W  (32),
         .ADDR_W  (16),
         .DEPTH_W (8),
         .WAIT    (2 * gi)
      ) u_dut (
         .clk   (clk),
         .rst_f (rst_f),
         .req   (req),
         .we    (we),
         .addr  (addr),
         .wdata (wdata),
         .ack   (ack_w[gi]),
         .rdata (rd_w[gi]),
         .err   (err_w[gi]),
         .busy  (busy_w[gi])
      );
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // ------------------------------------------------------------ model
   int          edge_n = 0;
   bit          m_act [N];
   int          m_acc [N];
   bit          m_we  [N];
   logic [15:0] m_addr[N];
   logic [31:0] m_wd  [N];
   bit          m_rl  [N];
   bit          m_re  [N];
   bit          m_rk  [N];
   logic [31:0] m_rd  [N];
   logic [31:0] m_hold[N];
   bit          m_hk  [N];
   logic [31:0] m_mem  [N][256];
   bit          m_known[N][256];
   bit          m_oor;
   logic [7:0]  m_idx;

   always @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         for (int i = 0; i < N; i++) begin
            m_act[i]  = 1'b0;
            m_hold[i] = '0;
            m_hk[i]   = 1'b1;
         end
      end else begin
         edge_n++;
         for (int i = 0; i < N; i++) begin
            if (m_act[i] && edge_n == m_acc[i] + 2 * i + 1) begin
               if (m_rl[i]) begin
                  m_hold[i] = m_rd[i];
                  m_hk[i]   = m_rk[i];
               end
               m_act[i] = 1'b0;
            end else if (!m_act[i] && req) begin
               m_act[i]  = 1'b1;
               m_acc[i]  = edge_n;
               m_we[i]   = we;
               m_addr[i] = addr;
               m_wd[i]   = wdata;
            end
            if (m_act[i] && edge_n == m_acc[i] + 2 * i) begin
               m_oor   = (m_addr[i] > 16'h00FF);
               m_idx   = m_addr[i][7:0];
               m_re[i] = m_oor;
               m_rl[i] = !m_we[i];
               if (m_we[i]) begin
                  if (!m_oor) begin
                     m_mem[i][m_idx]   = m_wd[i];
                     m_known[i][m_idx] = 1'b1;
                  end
               end else begin
                  m_rd[i] = m_oor ? 32'h0 : m_mem[i][m_idx];
                  m_rk[i] = m_oor || m_known[i][m_idx];
               end
            end
         end
      end
   end

   // ---------------------------------------------------------- compare
   bit e_ack;

   always @(negedge clk) begin
      if (rst_f) begin
         for (int i = 0; i < N; i++) begin
            e_ack = m_act[i] && (edge_n == m_acc[i] + 2 * i);
            chk($sformatf("d%0d ack", i), 32'(ack_w[i]), 32'(e_ack));
            chk($sformatf("d%0d busy", i), 32'(busy_w[i]), 32'(m_act[i]));
            chk($sformatf("d%0d err", i), 32'(err_w[i]), 32'(e_ack && m_re[i]));
            if (e_ack && m_rl[i]) begin
               if (m_rk[i]) chk($sformatf("d%0d rdata", i), rd_w[i], m_rd[i]);
            end else if (m_hk[i]) begin
               chk($sformatf("d%0d rdata hold", i), rd_w[i], m_hold[i]);
            end
         end
      end
   end

   // --------------------------------------------------------- stimulus
   task automatic op(input int i, input logic w, input logic [15:0] a,
                     input logic [31:0] d, output logic [31:0] rd,
                     output logic er, output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (m_act[i] && n < 40) begin
         @(negedge clk);
         n++;
      end
      req = 1'b1; we = w; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0; we = 1'($urandom_range(0, 1)); addr = 16'($urandom); wdata = $urandom;
      lat = 1;
      while (!ack_w[i] && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      rd = rd_w[i];
      er = err_w[i];
      if (!ack_w[i]) begin
         n_cmp++;
         n_bad++;
         $display("FAIL d%0d ack timeout: got no ack, required one within 30 cycles", i);
      end
   endtask

   task automatic wait_idle(input int i);
      int n;
      n = 0;
      @(negedge clk);
      while (m_act[i] && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          nack;
      int          cnt;
      logic [31:0] b_rd [3];
      int          b_edge [3];

      repeat (3) @(negedge clk);
      rst_f = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         chk("reset ack", 32'(ack_w[i]), 32'd0);
         chk("reset busy", 32'(busy_w[i]), 32'd0);
         chk("reset rdata", rd_w[i], 32'd0);
      end

      // Store then load, WAIT = 2
      op(1, 1'b1, 16'h0010, 32'hDEADBEEF, rd, er, lat);
      chk("st latency w2", 32'(lat), 32'd3);
      chk("st err", 32'(er), 32'd0);
      op(1, 1'b0, 16'h0010, 32'h0, rd, er, lat);
      chk("ld latency w2", 32'(lat), 32'd3);
      chk("ld rdata", rd, 32'hDEADBEEF);

      // WAIT = 0 back-to-back with req held
      op(0, 1'b1, 16'h0001, 32'h11, rd, er, lat);
      chk("st latency w0", 32'(lat), 32'd1);
      op(0, 1'b1, 16'h0002, 32'h22, rd, er, lat);
      wait_idle(0);
      for (int k = 0; k < 3; k++) begin
         b_rd[k]   = '0;
         b_edge[k] = 0;
      end
      req = 1'b1; we = 1'b0; addr = 16'h0001;
      nack = 0;
      cnt  = 0;
      while (cnt < 14 && nack < 3) begin
         @(negedge clk);
         if (ack_w[0]) begin
            b_rd[nack]   = rd_w[0];
            b_edge[nack] = edge_n;
            nack++;
            addr = (addr == 16'h0001) ? 16'h0002 : 16'h0001;
         end
         cnt++;
      end
      req = 1'b0;
      chk("b2b acks", 32'(nack), 32'd3);
      chk("b2b rd0", b_rd[0], 32'h11);
      chk("b2b rd1", b_rd[1], 32'h22);
      chk("b2b rd2", b_rd[2], 32'h11);
      chk("b2b gap01", 32'(b_edge[1] - b_edge[0]), 32'd2);
      chk("b2b gap12", 32'(b_edge[2] - b_edge[1]), 32'd2);

      // Out of range
      op(1, 1'b1, 16'h0000, 32'hCAFEF00D, rd, er, lat);
      op(1, 1'b0, 16'h0100, 32'h0, rd, er, lat);
      chk("oor ld err", 32'(er), 32'd1);
      chk("oor ld rdata", rd, 32'd0);
      op(1, 1'b1, 16'h0100, 32'h0BAD0BAD, rd, er, lat);
      chk("oor st err", 32'(er), 32'd1);
      op(1, 1'b0, 16'h0000, 32'h0, rd, er, lat);
      chk("oor alias rdata", rd, 32'hCAFEF00D);
      chk("oor alias err", 32'(er), 32'd0);

      // Inputs ignored while WAITING
      op(1, 1'b1, 16'h0005, 32'h55, rd, er, lat);
      op(1, 1'b1, 16'h0006, 32'h66, rd, er, lat);
      wait_idle(1);
      req = 1'b1; we = 1'b0; addr = 16'h0005;
      @(negedge clk);
      we = 1'b1; addr = 16'h0006; wdata = 32'hFFFF0000;
      @(negedge clk);
      req = 1'b0;
      cnt = 0;
      while (!ack_w[1] && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      chk("stable ack", 32'(ack_w[1]), 32'd1);
      chk("stable rdata", rd_w[1], 32'h55);
      op(1, 1'b0, 16'h0006, 32'h0, rd, er, lat);
      chk("stable no write", rd, 32'h66);

      // Reset during WAITING, WAIT = 4
      op(2, 1'b1, 16'h0020, 32'hA5A5A5A5, rd, er, lat);
      chk("st latency w4", 32'(lat), 32'd5);
      wait_idle(2);
      req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 32'h12345678;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      chk("midrst busy before", 32'(busy_w[2]), 32'd1);
      chk("midrst ack before", 32'(ack_w[2]), 32'd0);
      #2 rst_f = 1'b0;
      #1;
      chk("midrst busy", 32'(busy_w[2]), 32'd0);
      chk("midrst ack", 32'(ack_w[2]), 32'd0);
      @(negedge clk);
      rst_f = 1'b1;
      op(2, 1'b0, 16'h0020, 32'h0, rd, er, lat);
      chk("midrst old data", rd, 32'hA5A5A5A5);

      // Asynchronous reset in an ack cycle with err and rdata non-zero
      op(1, 1'b0, 16'h0010, 32'h0, rd, er, lat);
      chk("pre-rst load", rd, 32'hDEADBEEF);
      op(1, 1'b1, 16'h0100, 32'h1, rd, er, lat);
      chk("pre-rst err", 32'(er), 32'd1);
      chk("pre-rst rdata", rd, 32'hDEADBEEF);
      #2 rst_f = 1'b0;
      #1;
      chk("async rst ack", 32'(ack_w[1]), 32'd0);
      chk("async rst err", 32'(err_w[1]), 32'd0);
      chk("async rst busy", 32'(busy_w[1]), 32'd0);
      chk("async rst rdata", rd_w[1], 32'd0);
      @(negedge clk);
      rst_f = 1'b1;

      // Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         req   = ($urandom_range(0, 2) != 0);
         we    = 1'($urandom_range(0, 1));
         addr  = ($urandom_range(0, 9) == 0) ? (16'h0100 + 16'($urandom_range(0, 255)))
                                             : 16'($urandom_range(0, 47));
         wdata = $urandom;
      end
      @(negedge clk);
      req = 1'b0;
      repeat (12) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
